// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: arbitrates movement, jump, punch/kick attack phases and hitstun.
// Everything advances once per frame strobe SCEN; only hit capture happens on other cycles.
module player_action_ctrl #(
    parameter int CNT_WIDTH       = 5,
    parameter int STARTUP_FRAMES  = 3,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 6,
    parameter int KICK_EXTRA      = 2,
    parameter int HITSTUN_FRAMES  = 12,
    parameter int BUFFER_FRAMES   = 4,
    parameter int JUMP_TIMEOUT    = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       game_active,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       hit_taken,
    input  logic       jump_active,
    output logic       move_enable,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       attack_active,
    output logic       attack_type,
    output logic       hitbox_valid,
    output logic       hitstun_active,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOVE     = 3'd1,
        JUMP     = 3'd2,
        STARTUP  = 3'd3,
        ACTIVE   = 3'd4,
        RECOVERY = 3'd5,
        HITSTUN  = 3'd6
    } state_t;

    // Terminal counter values: a timed state exits on the SCEN where cnt equals its last value.
    localparam logic [CNT_WIDTH-1:0] CNT_ONE          = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] PUNCH_START_LAST = CNT_WIDTH'(STARTUP_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] KICK_START_LAST  = CNT_WIDTH'(STARTUP_FRAMES + KICK_EXTRA - 1);
    localparam logic [CNT_WIDTH-1:0] ACTIVE_LAST      = CNT_WIDTH'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] PUNCH_REC_LAST   = CNT_WIDTH'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] KICK_REC_LAST    = CNT_WIDTH'(RECOVERY_FRAMES + KICK_EXTRA - 1);
    localparam logic [CNT_WIDTH-1:0] HITSTUN_LAST     = CNT_WIDTH'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] BUFFER_LAST      = CNT_WIDTH'(BUFFER_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] JUMP_LAST        = CNT_WIDTH'(JUMP_TIMEOUT);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] bufAge_q, bufAge_d;
    logic                 atkType_q, atkType_d;
    logic                 bufValid_q, bufValid_d;
    logic                 bufType_q, bufType_d;
    logic                 hitPending_q, hitPending_d;
    logic                 punchPrev_q, kickPrev_q;

    logic moveEnable_q, moveLeft_q, moveRight_q, jump_q;
    logic attackActive_q, attackType_q, hitboxValid_q, hitstunActive_q;

    logic                 punchPress, kickPress, attackPress, hitNow;
    logic                 dirLeft, dirRight, driveDir, takeoff;
    logic                 enterHitstun, enterAttack, newType;
    logic [CNT_WIDTH-1:0] startupLast, recoveryLast;
    state_t               dirState;

    assign punchPress   = btn_punch & ~punchPrev_q;
    assign kickPress    = btn_kick & ~kickPrev_q;
    assign attackPress  = punchPress | kickPress;
    assign hitNow       = hitPending_q | hit_taken;
    assign dirLeft      = btn_left & ~btn_right;
    assign dirRight     = btn_right & ~btn_left;
    assign dirState     = (dirLeft | dirRight) ? MOVE : IDLE;
    assign startupLast  = atkType_q ? KICK_START_LAST : PUNCH_START_LAST;
    assign recoveryLast = atkType_q ? KICK_REC_LAST : PUNCH_REC_LAST;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        atkType_d    = atkType_q;
        bufValid_d   = bufValid_q;
        bufType_d    = bufType_q;
        bufAge_d     = bufAge_q;
        hitPending_d = hitNow;
        driveDir     = 1'b0;
        takeoff      = 1'b0;
        enterHitstun = 1'b0;
        enterAttack  = 1'b0;
        newType      = kickPress;
        if (SCEN) begin
            if (bufValid_q) begin
                if (bufAge_q == BUFFER_LAST) bufValid_d = 1'b0;
                else                         bufAge_d   = bufAge_q + CNT_ONE;
            end
            unique case (state_q)
                IDLE, MOVE: begin
                    if (hitNow) enterHitstun = 1'b1;
                    else if (attackPress) enterAttack = 1'b1;
                    else if (btn_jump) begin
                        state_d  = JUMP;
                        cnt_d    = '0;
                        takeoff  = 1'b1;
                        driveDir = 1'b1;
                    end else begin
                        state_d  = dirState;
                        driveDir = 1'b1;
                    end
                end
                // Hits wait until the jump is over; attack presses are simply dropped.
                JUMP: begin
                    if ((!jump_active && cnt_q != '0) || cnt_q == JUMP_LAST) begin
                        if (hitNow) enterHitstun = 1'b1;
                        else        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STARTUP: begin
                    if (hitNow) enterHitstun = 1'b1;
                    else if (cnt_q == startupLast) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + CNT_ONE;
                end
                ACTIVE: begin
                    if (hitNow) enterHitstun = 1'b1;
                    else begin
                        if (attackPress) begin
                            bufValid_d = 1'b1;
                            bufType_d  = kickPress;
                            bufAge_d   = '0;
                        end
                        if (cnt_q == ACTIVE_LAST) begin
                            state_d = RECOVERY;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // A press on the final recovery frame counts as a fresh buffer entry.
                RECOVERY: begin
                    if (hitNow) enterHitstun = 1'b1;
                    else if (cnt_q == recoveryLast) begin
                        if (attackPress) enterAttack = 1'b1;
                        else if (bufValid_q) begin
                            enterAttack = 1'b1;
                            newType     = bufType_q;
                        end else begin
                            state_d  = dirState;
                            driveDir = 1'b1;
                        end
                    end else begin
                        if (attackPress) begin
                            bufValid_d = 1'b1;
                            bufType_d  = kickPress;
                            bufAge_d   = '0;
                        end
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HITSTUN: begin
                    if (hitNow) enterHitstun = 1'b1;
                    else if (cnt_q == HITSTUN_LAST) state_d = IDLE;
                    else cnt_d = cnt_q + CNT_ONE;
                end
                default: state_d = IDLE;
            endcase
            if (enterHitstun) begin
                state_d      = HITSTUN;
                cnt_d        = '0;
                bufValid_d   = 1'b0;
                hitPending_d = 1'b0;
            end
            if (enterAttack) begin
                state_d    = STARTUP;
                cnt_d      = '0;
                atkType_d  = newType;
                bufValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !game_active) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bufAge_q        <= '0;
            atkType_q       <= 1'b0;
            bufValid_q      <= 1'b0;
            bufType_q       <= 1'b0;
            hitPending_q    <= 1'b0;
            punchPrev_q     <= 1'b0;
            kickPrev_q      <= 1'b0;
            moveEnable_q    <= 1'b0;
            moveLeft_q      <= 1'b0;
            moveRight_q     <= 1'b0;
            jump_q          <= 1'b0;
            attackActive_q  <= 1'b0;
            attackType_q    <= 1'b0;
            hitboxValid_q   <= 1'b0;
            hitstunActive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bufAge_q     <= bufAge_d;
            atkType_q    <= atkType_d;
            bufValid_q   <= bufValid_d;
            bufType_q    <= bufType_d;
            hitPending_q <= hitPending_d;
            if (SCEN) begin
                punchPrev_q     <= btn_punch;
                kickPrev_q      <= btn_kick;
                moveEnable_q    <= (state_d == IDLE) || (state_d == MOVE) || (state_d == JUMP);
                moveLeft_q      <= driveDir & dirLeft;
                moveRight_q     <= driveDir & dirRight;
                jump_q          <= takeoff;
                attackActive_q  <= state_d inside {STARTUP, ACTIVE, RECOVERY};
                attackType_q    <= atkType_d & (state_d inside {STARTUP, ACTIVE, RECOVERY});
                hitboxValid_q   <= (state_d == ACTIVE);
                hitstunActive_q <= (state_d == HITSTUN);
            end
        end
    end

    assign move_enable    = moveEnable_q;
    assign move_left      = moveLeft_q;
    assign move_right     = moveRight_q;
    assign jump           = jump_q;
    assign attack_active  = attackActive_q;
    assign attack_type    = attackType_q;
    assign hitbox_valid   = hitboxValid_q;
    assign hitstun_active = hitstunActive_q;
    assign state          = state_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Bench for player_action_ctrl: directed scenarios then random frames, all compared against
// a phase-plan reference model after every SCEN and after the following idle cycle.
module tb_player_action_ctrl;

    localparam int CNT_WIDTH       = 5;
    localparam int STARTUP_FRAMES  = 3;
    localparam int ACTIVE_FRAMES   = 2;
    localparam int RECOVERY_FRAMES = 6;
    localparam int KICK_EXTRA      = 2;
    localparam int HITSTUN_FRAMES  = 12;
    localparam int BUFFER_FRAMES   = 4;
    localparam int JUMP_TIMEOUT    = 31;

    logic clk = 1'b0;
    logic reset, SCEN, gameActive, btnLeft, btnRight, btnJump, btnPunch, btnKick, hitTaken, jumpActive;
    logic moveEnable, moveLeft, moveRight, jump, attackActive, attackType, hitboxValid, hitstunActive;
    logic [2:0] state;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: timed sequences are kept as a queue of per-frame state codes.
    int  mState, mType, jumpAge, frameNo, bufFrame;
    bit  bufValid, bufType, hitPend, prevP, prevK, expJump, expML, expMR, outputsCleared;
    int  plan[$];

    player_action_ctrl #(
        .CNT_WIDTH(CNT_WIDTH), .STARTUP_FRAMES(STARTUP_FRAMES), .ACTIVE_FRAMES(ACTIVE_FRAMES),
        .RECOVERY_FRAMES(RECOVERY_FRAMES), .KICK_EXTRA(KICK_EXTRA), .HITSTUN_FRAMES(HITSTUN_FRAMES),
        .BUFFER_FRAMES(BUFFER_FRAMES), .JUMP_TIMEOUT(JUMP_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .SCEN(SCEN), .game_active(gameActive),
        .btn_left(btnLeft), .btn_right(btnRight), .btn_jump(btnJump),
        .btn_punch(btnPunch), .btn_kick(btnKick), .hit_taken(hitTaken),
        .jump_active(jumpActive), .move_enable(moveEnable), .move_left(moveLeft),
        .move_right(moveRight), .jump(jump), .attack_active(attackActive),
        .attack_type(attackType), .hitbox_valid(hitboxValid),
        .hitstun_active(hitstunActive), .state(state)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mState = 0; mType = 0; jumpAge = 0; frameNo = 0; bufFrame = 0;
        bufValid = 0; bufType = 0; hitPend = 0; prevP = 0; prevK = 0;
        expJump = 0; expML = 0; expMR = 0; outputsCleared = 1;
        plan.delete();
    endtask

    task automatic startAttack(input int t);
        mType = t; bufValid = 0; plan.delete();
        repeat (STARTUP_FRAMES + t * KICK_EXTRA) plan.push_back(3);
        repeat (ACTIVE_FRAMES) plan.push_back(4);
        repeat (RECOVERY_FRAMES + t * KICK_EXTRA) plan.push_back(5);
        mState = 3;
    endtask

    task automatic startHitstun();
        plan.delete();
        repeat (HITSTUN_FRAMES) plan.push_back(6);
        mState = 6; bufValid = 0; hitPend = 0;
    endtask

    task automatic settle(input bit dl, input bit dr);
        mState = (dl || dr) ? 1 : 0;
        expML = dl; expMR = dr;
    endtask

    task automatic modelFrame(input bit hitNow);
        bit pP, pK, press, dl, dr;
        pP = btnPunch && !prevP;
        pK = btnKick && !prevK;
        press = pP || pK;
        prevP = btnPunch; prevK = btnKick;
        frameNo++;
        hitPend = hitNow;
        dl = btnLeft && !btnRight;
        dr = btnRight && !btnLeft;
        outputsCleared = 0; expJump = 0; expML = 0; expMR = 0;
        case (mState)
            0, 1: begin
                if (hitNow) startHitstun();
                else if (press) startAttack(pK ? 1 : 0);
                else if (btnJump) begin
                    mState = 2; jumpAge = 0; expJump = 1; expML = dl; expMR = dr;
                end else settle(dl, dr);
            end
            2: begin
                if ((!jumpActive && jumpAge >= 1) || jumpAge == JUMP_TIMEOUT) begin
                    if (hitNow) startHitstun();
                    else mState = 0;
                end else jumpAge++;
            end
            3, 4, 5: begin
                if (hitNow) startHitstun();
                else begin
                    if (press && mState != 3) begin
                        bufValid = 1; bufType = pK; bufFrame = frameNo;
                    end
                    void'(plan.pop_front());
                    if (plan.size() > 0) mState = plan[0];
                    else if (bufValid && (frameNo - bufFrame) <= BUFFER_FRAMES) startAttack(bufType ? 1 : 0);
                    else settle(dl, dr);
                end
            end
            default: begin
                if (hitNow) startHitstun();
                else begin
                    void'(plan.pop_front());
                    mState = (plan.size() > 0) ? plan[0] : 0;
                end
            end
        endcase
    endtask

    task automatic modelEdge();
        if (reset || !gameActive) modelReset();
        else if (SCEN) modelFrame(hitPend || hitTaken);
        else hitPend = hitPend || hitTaken;
    endtask

    task automatic checkVal(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string where);
        bit atk;
        atk = (mState >= 3 && mState <= 5);
        checkVal({where, ".state"}, state, 3'(mState));
        checkVal({where, ".move_enable"}, 3'(moveEnable), 3'(!outputsCleared && mState <= 2));
        checkVal({where, ".move_left"}, 3'(moveLeft), 3'(expML));
        checkVal({where, ".move_right"}, 3'(moveRight), 3'(expMR));
        checkVal({where, ".jump"}, 3'(jump), 3'(expJump));
        checkVal({where, ".attack_active"}, 3'(attackActive), 3'(atk));
        checkVal({where, ".attack_type"}, 3'(attackType), 3'(atk && mType == 1));
        checkVal({where, ".hitbox_valid"}, 3'(hitboxValid), 3'(mState == 4));
        checkVal({where, ".hitstun_active"}, 3'(hitstunActive), 3'(mState == 6));
    endtask

    // One frame: a SCEN cycle followed by an idle cycle, checked after each.
    task automatic applyStimulus(input bit hitWithScen);
        @(negedge clk); SCEN = 1; hitTaken = hitWithScen;
        @(posedge clk); modelEdge();
        @(negedge clk); SCEN = 0; hitTaken = 0; checkOutput("scen");
        @(posedge clk); modelEdge();
        @(negedge clk); checkOutput("hold");
    endtask

    task automatic hitOffScen();
        @(negedge clk); hitTaken = 1;
        @(posedge clk); modelEdge();
        @(negedge clk); hitTaken = 0; checkOutput("hitoff");
    endtask

    task automatic pulseReset(input bit withScen, input bit viaGame);
        @(negedge clk);
        if (viaGame) gameActive = 0; else reset = 1;
        SCEN = withScen; hitTaken = 0;
        @(posedge clk); modelEdge();
        @(negedge clk); reset = 0; gameActive = 1; SCEN = 0; checkOutput("reset");
    endtask

    task automatic punchIntoActive();
        btnPunch = 1; applyStimulus(0);
        btnPunch = 0; repeat (3) applyStimulus(0);
    endtask

    initial begin
        reset = 1; gameActive = 0; SCEN = 0; hitTaken = 0; jumpActive = 0;
        btnLeft = 0; btnRight = 0; btnJump = 0; btnPunch = 0; btnKick = 0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk); checkOutput("init");
        checkVal("init.move_enable_low", 3'(moveEnable), 3'd0);
        reset = 0; gameActive = 1;

        btnRight = 1; repeat (3) applyStimulus(0);
        checkVal("move.state", state, 3'd1);
        checkVal("move.right", 3'(moveRight), 3'd1);
        btnRight = 0; applyStimulus(0);
        checkVal("move.release", state, 3'd0);

        btnPunch = 1; applyStimulus(0);
        checkVal("punch.startup", state, 3'd3);
        btnPunch = 0; repeat (12) applyStimulus(0);
        btnKick = 1; applyStimulus(0);
        btnKick = 0; repeat (16) applyStimulus(0);

        for (int i = 0; i < 20; i++) begin
            btnPunch = (i == 0 || i == 8); btnKick = (i == 10);
            applyStimulus(0);
            if (i == 11) begin
                checkVal("buffer.kick_state", state, 3'd3);
                checkVal("buffer.kick_type", 3'(attackType), 3'd1);
            end
        end
        btnPunch = 0; btnKick = 0; repeat (16) applyStimulus(0);

        for (int i = 0; i < 14; i++) begin
            btnPunch = (i == 0 || i == 6);
            applyStimulus(0);
            if (i == 11) checkVal("buffer.expired", state, 3'd0);
        end
        btnPunch = 0;

        btnLeft = 1; btnJump = 1; applyStimulus(0);
        checkVal("jump.pulse", 3'(jump), 3'd1);
        checkVal("jump.drift", 3'(moveLeft), 3'd1);
        btnLeft = 0; btnJump = 0; jumpActive = 1;
        repeat (16) applyStimulus(0);
        jumpActive = 0; applyStimulus(0);
        checkVal("jump.land", state, 3'd0);

        btnJump = 1; applyStimulus(0);
        btnJump = 0; jumpActive = 1; repeat (31) applyStimulus(0);
        checkVal("jump.stuck", state, 3'd2);
        applyStimulus(0);
        checkVal("jump.timeout", state, 3'd0);
        jumpActive = 0;

        punchIntoActive();
        btnKick = 1; applyStimulus(0);
        btnKick = 0; hitOffScen(); applyStimulus(0);
        checkVal("hit.hitstun", state, 3'd6);
        repeat (7) applyStimulus(0);
        hitOffScen(); repeat (12) applyStimulus(0);
        checkVal("hit.restarted", state, 3'd6);
        applyStimulus(0);
        checkVal("hit.exit_no_buffer", state, 3'd0);

        applyStimulus(1);
        checkVal("hit.same_cycle", state, 3'd6);
        repeat (12) applyStimulus(0);

        for (int v = 0; v < 4; v++) begin
            punchIntoActive();
            pulseReset(v[0], v[1]);
            checkVal("abort.hitbox", 3'(hitboxValid), 3'd0);
        end

        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 3) == 0) btnLeft = ~btnLeft;
            if ($urandom_range(0, 3) == 0) btnRight = ~btnRight;
            btnJump  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) btnPunch = ~btnPunch;
            if ($urandom_range(0, 3) == 0) btnKick = ~btnKick;
            if ($urandom_range(0, 5) == 0) jumpActive = ~jumpActive;
            if ($urandom_range(0, 24) == 0) hitOffScen();
            if ($urandom_range(0, 99) == 0) pulseReset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            applyStimulus($urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/player_action_ctrl.md
Name: player_action_ctrl

Overview:
- Per-player action sequencer sitting between debounced button inputs and the player_move datapath.
- Arbitrates movement, jump, punch/kick attacks and hitstun.
- Drives player_move's move_enable/move_left/move_right/jump and supplies attack-phase status to the hit-detection and sprite logic.
- Advances on the frame strobe SCEN only.

Parameters:
- CNT_WIDTH, 5, width of the frame counter and buffer-age counter.
- STARTUP_FRAMES, 3, punch startup length (frames).
- ACTIVE_FRAMES, 2, hitbox-live length (frames), same for punch and kick.
- RECOVERY_FRAMES, 6, punch recovery length (frames).
- KICK_EXTRA, 2, frames added to startup and to recovery for kick.
- HITSTUN_FRAMES, 12, hitstun length (frames).
- BUFFER_FRAMES, 4, lifetime of a buffered attack press (frames).
- JUMP_TIMEOUT, 31, maximum frames in JUMP before forced exit.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- SCEN, in, 1, one-cycle frame strobe.
- game_active, in, 1, round running.
- btn_left, in, 1, debounced left button level.
- btn_right, in, 1, debounced right button level.
- btn_jump, in, 1, debounced jump button level.
- btn_punch, in, 1, debounced punch button level.
- btn_kick, in, 1, debounced kick button level.
- hit_taken, in, 1, any-cycle pulse: this player was hit.
- jump_active, in, 1, from player_move.
- move_enable, out, 1, to player_move.
- move_left, out, 1, to player_move.
- move_right, out, 1, to player_move.
- jump, out, 1, to player_move.
- attack_active, out, 1, high in STARTUP, ACTIVE and RECOVERY.
- attack_type, out, 1, 0=punch, 1=kick; valid while attack_active.
- hitbox_valid, out, 1, high in ACTIVE.
- hitstun_active, out, 1, high in HITSTUN.
- state, out, 3, current state code.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high. Reset puts the block in IDLE (state=0), clears all outputs, counters, edge registers, attack buffer and hit_pending.
- State codes: IDLE=0, MOVE=1, JUMP=2, STARTUP=3, ACTIVE=4, RECOVERY=5, HITSTUN=6.
- Frame timing:
  - State, counters and outputs change only on edges where SCEN=1. The only exceptions are reset, game_active=0 and hit_pending capture.
  - All outputs are registered and reflect the new state from the cycle after the SCEN edge.
- game_active=0 on any edge has the same effect as reset.
- hit_pending: set on any cycle with hit_taken=1; cleared when consumed.
- Edge detection:
  - Punch and kick presses are rising edges sampled on SCEN: press = btn & ~prev, and prev updates on SCEN.
  - Simultaneous punch and kick presses resolve to kick.
- Priority at each SCEN (highest first): hit_pending > attack press > jump > move.
- Phase lengths:
  - Entering a timed state sets cnt=0. Each SCEN in the state either exits when cnt==len-1 or increments cnt.
  - The state therefore lasts exactly len frames.
  - STARTUP len = STARTUP_FRAMES + type*KICK_EXTRA.
  - ACTIVE len = ACTIVE_FRAMES.
  - RECOVERY len = RECOVERY_FRAMES + type*KICK_EXTRA.
  - HITSTUN len = HITSTUN_FRAMES.
- IDLE/MOVE:
  - move_enable=1.
  - move_left = btn_left & ~btn_right; move_right = btn_right & ~btn_left.
  - State is MOVE if exactly one direction is held, else IDLE.
  - Attack press → STARTUP; attack_type latched; move outputs 0.
  - btn_jump → JUMP; jump=1 for exactly one frame with move_left/move_right as computed, which sets the takeoff drift.
- JUMP:
  - After the takeoff frame: jump=0, move_left=move_right=0, move_enable=1.
  - Exit to IDLE on SCEN when jump_active=0 and cnt≥1, or when cnt==JUMP_TIMEOUT.
  - Attack presses and hit_pending are deferred; hit_pending is consumed on exit, going to HITSTUN instead of IDLE.
- STARTUP → ACTIVE → RECOVERY → IDLE (or MOVE per buttons).
  - move_enable=0 throughout.
  - hit_pending in any attack state → HITSTUN immediately; the buffer is cleared.
- Attack buffer:
  - A press in ACTIVE or RECOVERY stores type and sets age=0. A later press overwrites it.
  - Age increments each SCEN; the buffer is invalidated when age==BUFFER_FRAMES.
  - At the end of RECOVERY, a valid buffer → STARTUP with the buffered type, skipping IDLE; the buffer is cleared.
  - Presses in STARTUP are ignored.
- HITSTUN:
  - move_enable=0, attack_active=0.
  - hit_pending in HITSTUN restarts cnt=0; all presses are ignored.
  - Exit → IDLE.
- hit_taken and SCEN in the same cycle: treated as pending for that SCEN, i.e. takes effect on that edge.

Test Plan:
- Reset, then btn_right held for 3 SCEN frames → state=1, move_right=1, move_enable=1. Release → state=0 at the next SCEN.
- Punch edge in IDLE → STARTUP for 3 frames, ACTIVE for 2 (hitbox_valid=1), RECOVERY for 6, then IDLE. Kick → 5/2/8. move_enable=0 for all 11 (punch) or 15 (kick) frames.
- Punch pressed in RECOVERY frame 3, kick pressed in frame 5 → STARTUP as kick directly after RECOVERY. A press at RECOVERY frame 1 of a 6-frame recovery has expired by the end → IDLE.
- btn_jump with btn_left held → jump=1 and move_left=1 for one frame, then 0. jump_active high for 16 frames then low → IDLE on the next SCEN. jump_active stuck at 1 → IDLE after 31 frames.
- hit_taken mid-ACTIVE, off-SCEN → HITSTUN at the next SCEN, buffer cleared, hitstun for 12 frames. A second hit at HITSTUN frame 8 → 12 more frames.
- reset or game_active=0 during ACTIVE → all outputs 0 and state=0 the next cycle, with or without SCEN.
